// File: rtl/mdu_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mdu_multicycle : multi-cycle multiply/divide unit with HI/LO registers      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mdu_multicycle #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Stall_Req
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_MULT_CNT = c_CNT_W'(MULT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_DIV_CNT  = c_CNT_W'(DIV_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             r_state, w_state_next;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_next;
  logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
  logic [WIDTH-1:0]   w_a_next, w_b_next, w_hi_next, w_lo_next;
  logic [1:0]         r_op, w_op_next;

  logic [2*WIDTH-1:0] w_prod;
  logic               w_sign_a, w_sign_b, w_signed_op;
  logic [WIDTH-1:0]   w_dvd, w_dvs, w_uq, w_ur, w_quo, w_rem;

  // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product are then exact.
  assign w_signed_op = ~r_op[0];
  assign w_prod = {{WIDTH{w_signed_op & r_a[WIDTH-1]}}, r_a} *
                  {{WIDTH{w_signed_op & r_b[WIDTH-1]}}, r_b};

  // Signed divide runs on magnitudes, so most-negative / -1 wraps to most-negative naturally.
  assign w_sign_a = w_signed_op & r_a[WIDTH-1];
  assign w_sign_b = w_signed_op & r_b[WIDTH-1];
  assign w_dvd    = w_sign_a ? ({WIDTH{1'b0}} - r_a) : r_a;
  assign w_dvs    = w_sign_b ? ({WIDTH{1'b0}} - r_b) : r_b;
  assign w_uq     = w_dvd / w_dvs;
  assign w_ur     = w_dvd % w_dvs;
  assign w_quo    = (w_sign_a ^ w_sign_b) ? ({WIDTH{1'b0}} - w_uq) : w_uq;
  assign w_rem    = w_sign_a ? ({WIDTH{1'b0}} - w_ur) : w_ur;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_op    <= w_op_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_op_next    = r_op;
    w_hi_next    = r_hi;
    w_lo_next    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (!Op[2]) begin
            w_a_next     = A;
            w_b_next     = B;
            w_op_next    = Op[1:0];
            w_cnt_next   = Op[1] ? c_DIV_CNT : c_MULT_CNT;
            w_state_next = S_RUN;
          end else if (Op == 3'b100) begin
            w_hi_next = A;
          end else if (Op == 3'b101) begin
            w_lo_next = A;
          end
        end
      end
      S_RUN: begin
        w_cnt_next = r_cnt - c_CNT_ONE;
        if (r_cnt == c_CNT_ONE) begin
          w_state_next = S_IDLE;
          if (!r_op[1]) begin
            w_hi_next = w_prod[2*WIDTH-1:WIDTH];
            w_lo_next = w_prod[WIDTH-1:0];
          end else if (r_b != '0) begin
            w_hi_next = w_rem;
            w_lo_next = w_quo;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign HI        = r_hi;
  assign LO        = r_lo;
  assign Busy      = (r_state == S_RUN);
  assign Stall_Req = Busy | (Start & ~Op[2]);

endmodule
`default_nettype wire
